// File: rtl/com_ram_stream_reader.sv
// com_ram_stream_reader: streams len words from a 1-cycle-latency RAM port as valid/ready beats.
// A 2-entry output FIFO absorbs the read latency so no beat is lost under backpressure.
`default_nettype none

module com_ram_stream_reader #(
  parameter int WIDTH    = 72,
  parameter int ADDR_BIT = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BIT-1:0] base_addr,
  input  logic [ADDR_BIT:0]   len,
  output logic                busy,
  output logic                done,
  output logic [ADDR_BIT-1:0] ram_addr,
  input  logic [WIDTH-1:0]    ram_dout,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WIDTH-1:0]    m_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_BIT-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_BIT:0]   REM_ONE  = 1;

  logic [1:0]       state;
  logic [ADDR_BIT:0] remaining;
  logic             inflight;
  logic [1:0]       cnt;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [WIDTH-1:0] mem [0:1];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;
  logic [2:0] lim;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid & m_ready;
  assign push    = inflight;

  // Slots already claimed (buffered + in flight) minus the beat leaving this cycle must be < 2.
  always_comb begin
    occ   = {1'b0, cnt} + {2'b00, inflight};
    lim   = 3'd2 + {2'b00, pop};
    issue = (state == S_RUN) && (remaining != '0) && (occ < lim);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_addr  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            ram_addr  <= base_addr;
            remaining <= len;
            busy      <= 1'b1;
            state     <= (len == '0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            ram_addr  <= ram_addr + ADDR_ONE;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!inflight && (cnt == 2'd0)) state <= S_FIN;
        end
        default: begin
          // busy stays high through the done cycle; IDLE drops it one edge later.
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= issue;
      if (push) begin
        mem[wr_ptr] <= ram_dout;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire
